// File: rtl/cpu_controller_pkg.sv
// Shared opcode and phase constants plus the strobe bundle for the CPU instruction sequencer.
package cpu_controller_pkg;

  localparam int unsigned NUM_PHASES = 8;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned OPCODE_W   = 3;

  localparam logic [OPCODE_W-1:0] OPCODE_HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] OPCODE_SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] OPCODE_ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] OPCODE_AND = 3'd3;
  localparam logic [OPCODE_W-1:0] OPCODE_XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] OPCODE_LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] OPCODE_STO = 3'd6;
  localparam logic [OPCODE_W-1:0] OPCODE_JMP = 3'd7;

  localparam logic [PHASE_W-1:0] PHASE_INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] PHASE_IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] PHASE_OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] PHASE_OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] PHASE_ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] PHASE_STORE      = 3'd7;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes whose result comes back from memory through the ALU into the accumulator.
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_ADD) || (op == OPCODE_AND) ||
           (op == OPCODE_XOR) || (op == OPCODE_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// Wrapping instruction-phase counter; hold freezes it (used while halting).
module cpu_controller_phase_counter
  import cpu_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  output logic [PHASE_W-1:0] phase
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PHASE_INST_ADDR;
    end else if (!hold) begin
      phase <= phase + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: steps the 8-phase cycle and decodes datapath strobes
// from phase, opcode, ALU zero flag and the sticky halted flag.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [PHASE_W-1:0]  phase
);

  logic  halted;
  logic  halt_entry;
  logic  alu_op;
  ctrl_t ctrl;

  assign halt_entry = !halted && (phase == PHASE_OP_ADDR) && (opcode == OPCODE_HLT);
  assign alu_op     = is_alu_op(opcode);

  cpu_controller_phase_counter u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (halted | halt_entry),
    .phase (phase)
  );

  // Sticky halt; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (halt_entry) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl.halt = 1'b1;
    end else begin
      case (phase)
        PHASE_INST_ADDR: begin
          ctrl.sel = 1'b1;
        end
        PHASE_INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        PHASE_INST_LOAD, PHASE_IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        PHASE_OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == OPCODE_HLT);
        end
        PHASE_OP_FETCH: begin
          ctrl.rd = alu_op;
        end
        PHASE_ALU_OP: begin
          ctrl.rd     = alu_op;
          ctrl.inc_pc = (opcode == OPCODE_SKZ) && zero;
          ctrl.ld_pc  = (opcode == OPCODE_JMP);
          ctrl.data_e = (opcode == OPCODE_STO);
        end
        PHASE_STORE: begin
          ctrl.rd     = alu_op;
          ctrl.ld_ac  = alu_op;
          ctrl.ld_pc  = (opcode == OPCODE_JMP);
          ctrl.wr     = (opcode == OPCODE_STO);
          ctrl.data_e = (opcode == OPCODE_STO);
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign ld_ir  = ctrl.ld_ir;
  assign inc_pc = ctrl.inc_pc;
  assign halt   = ctrl.halt;
  assign ld_pc  = ctrl.ld_pc;
  assign data_e = ctrl.data_e;
  assign ld_ac  = ctrl.ld_ac;
  assign wr     = ctrl.wr;

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit RISC CPU; the control-side counterpart of the ALU.
- Steps a fixed 8-phase instruction cycle.
- Drives memory, PC, IR, accumulator and bus-enable strobes from the current IR opcode and the ALU zero flag.
- Sits between the instruction register and the datapath; the opcode it decodes is the same 3-bit field the ALU consumes.

Parameters:
- NUM_PHASES, 8, phases per instruction cycle; fixed, since phase state is 3 bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- opcode  input  3  IR opcode field (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7)
- zero  input  1  ALU zero flag (out == 0)
- sel  output  1  address mux select: 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC increment
- halt  output  1  CPU halted, sticky
- ld_pc  output  1  PC load from IR operand (jump)
- data_e  output  1  drive accumulator onto data bus
- ld_ac  output  1  accumulator load from ALU out
- wr  output  1  memory write strobe
- phase  output  3  current phase, for debug and trace

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- State:
  - 3-bit phase register: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
  - 1-bit halted flag.
- Reset (async assert, sync release): phase=INST_ADDR, halted=0.
  - Outputs during and after reset: sel=1, all other strobes 0, phase=0.
- Sequencing:
  - Each clk, phase <= phase+1, wrapping STORE -> INST_ADDR.
  - One instruction takes exactly 8 cycles.
- Halt:
  - In OP_ADDR with opcode==HLT: halt=1 that cycle; halted <= 1 at the edge; phase freezes at OP_ADDR.
  - While halted: halt=1, every other strobe 0, phase held.
  - Exit only via rst_n.
- Outputs are combinational decode of (phase, halted, opcode, zero). ALUOP = ADD|AND|XOR|LDA.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Opcode/zero timing:
  - opcode is ignored in phases 0-3, while the IR is still loading.
  - zero is sampled combinationally only in ALU_OP and only for SKZ; it is ignored elsewhere.
- Mutual exclusion (assertion targets):
  - wr implies data_e.
  - rd and wr never both 1.
  - ld_pc and inc_pc never both 1 in the same phase.
  - ld_ir only in phases 2-3.
- Reset mid-instruction: any phase, including halted, returns immediately to INST_ADDR with no wr or ld_ac pulse emitted.
- Unknown opcode values cannot occur (3-bit, fully decoded). Any X on opcode in phases 4-7 is a bench error.

Decomposition:
- defines.v (shared with the ALU):
  - the existing OPCODE_* constants;
  - new PHASE_* constants, 3'd0..3'd7.
- Optional sub-module phase_counter (3-bit wrapping counter with hold input, async active-low reset).
- Decode stays in cpu_controller as a single case on phase.

Test Plan:
- Reset then free-run with opcode=ADD, zero=0:
  - phases cycle 0..7 and wrap;
  - rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7;
  - inc_pc=1 only in phase 4.
- opcode=STO:
  - data_e=1 in phases 6 and 7; wr=1 only in phase 7;
  - rd=0 in phases 5-7; ld_ac never asserted.
- opcode=SKZ:
  - with zero=1, inc_pc=1 in phases 4 and 6 (two increments);
  - with zero=0, inc_pc=1 in phase 4 only.
- opcode=JMP: ld_pc=1 in phases 6 and 7; wr, ld_ac and data_e stay 0.
- opcode=HLT:
  - halt=1 from phase 4 onward; phase stays 4 for 20 cycles with all other strobes 0;
  - rst_n pulse returns phase=0 and halt=0.
- Drop rst_n asynchronously mid-phase 6 with opcode=STO:
  - outputs go immediately to sel=1, everything else 0;
  - after release, the sequence restarts at phase 0 with no wr pulse observed.
